// File: rtl/prf_free_list_pkg.sv
// rtl/prf_free_list_pkg.sv - shared sizes, types and helpers for the PRF free list
package prf_free_list_pkg;

  localparam int ARF_SIZE = 32;
  localparam int PRF_SIZE = 64;
  localparam int PRF_IDX  = 6;

  typedef logic [PRF_IDX-1:0]  prf_tag_t;
  typedef logic [PRF_SIZE-1:0] prf_vec_t;
  typedef logic [PRF_IDX:0]    prf_cnt_t;

  // Tags 0..ARF_SIZE-1 back the RAT identity map out of reset.
  localparam prf_vec_t RESET_FREE = {{(PRF_SIZE-ARF_SIZE){1'b1}}, {ARF_SIZE{1'b0}}};
  localparam prf_cnt_t RESET_COUNT = prf_cnt_t'(PRF_SIZE - ARF_SIZE);

  function automatic prf_cnt_t popcount(input prf_vec_t v);
    prf_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < PRF_SIZE; i++) cnt = cnt + prf_cnt_t'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/prf_two_lowest.sv
// rtl/prf_two_lowest.sv - lowest and second-lowest set index finder over a PRF bitmap
module prf_two_lowest
  import prf_free_list_pkg::*;
(
  input  logic [PRF_SIZE-1:0] vec,
  output prf_tag_t            idx_1,
  output prf_tag_t            idx_2,
  output logic                valid_1,
  output logic                valid_2
);

  prf_vec_t masked;

  // Scanning downward lets the last hit win, leaving the lowest index.
  always_comb begin
    idx_1   = '0;
    valid_1 = 1'b0;
    for (int i = PRF_SIZE - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx_1   = prf_tag_t'(i);
        valid_1 = 1'b1;
      end
    end
  end

  assign masked = valid_1 ? (vec & ~(prf_vec_t'(1) << idx_1)) : vec;

  always_comb begin
    idx_2   = '0;
    valid_2 = 1'b0;
    for (int i = PRF_SIZE - 1; i >= 0; i--) begin
      if (masked[i]) begin
        idx_2   = prf_tag_t'(i);
        valid_2 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prf_free_list.sv
// rtl/prf_free_list.sv - 2-wide physical register free list with retire reclaim and RRAT flush rebuild
module prf_free_list
  import prf_free_list_pkg::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              used_1,
  input  logic                              used_2,
  input  logic                              retire_en_1,
  input  prf_tag_t                          retire_old_1,
  input  logic                              retire_en_2,
  input  prf_tag_t                          retire_old_2,
  input  logic                              flush,
  input  logic [ARF_SIZE-1:0][PRF_IDX-1:0]  rrat_prf_out,
  output prf_tag_t                          free_reg_1,
  output prf_tag_t                          free_reg_2,
  output logic                              free_valid_1,
  output logic                              free_valid_2,
  output prf_cnt_t                          free_count,
  output logic                              rename_stall
);

  prf_vec_t free_bits;
  prf_vec_t alloc_mask;
  prf_vec_t kept_bits;
  prf_vec_t retire_mask;
  prf_vec_t mapped_mask;
  prf_cnt_t n_alloc;
  prf_cnt_t n_retire;
  prf_cnt_t count_next;

  prf_two_lowest u_two_lowest (
    .vec     (free_bits),
    .idx_1   (free_reg_1),
    .idx_2   (free_reg_2),
    .valid_1 (free_valid_1),
    .valid_2 (free_valid_2)
  );

  // A lone used_2 takes free_reg_1; requests beyond the free supply are dropped.
  always_comb begin
    alloc_mask = '0;
    n_alloc    = '0;
    if ((used_1 || used_2) && free_valid_1) begin
      alloc_mask[free_reg_1] = 1'b1;
      n_alloc                = prf_cnt_t'(1);
    end
    if (used_1 && used_2 && free_valid_2) begin
      alloc_mask[free_reg_2] = 1'b1;
      n_alloc                = n_alloc + prf_cnt_t'(1);
    end
  end

  assign kept_bits = free_bits & ~alloc_mask;

  // Only retires that actually flip a bit are counted, so count tracks the bitmap.
  always_comb begin
    retire_mask = '0;
    n_retire    = '0;
    if (retire_en_1) begin
      retire_mask[retire_old_1] = 1'b1;
      if (!kept_bits[retire_old_1]) n_retire = prf_cnt_t'(1);
    end
    if (retire_en_2) begin
      retire_mask[retire_old_2] = 1'b1;
      if (!kept_bits[retire_old_2] && !(retire_en_1 && retire_old_1 == retire_old_2))
        n_retire = n_retire + prf_cnt_t'(1);
    end
  end

  assign count_next = free_count - n_alloc + n_retire;

  always_comb begin
    mapped_mask = '0;
    for (int a = 0; a < ARF_SIZE; a++) mapped_mask[rrat_prf_out[a]] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_bits  <= RESET_FREE;
      free_count <= RESET_COUNT;
    end else if (flush) begin
      free_bits  <= ~mapped_mask;
      free_count <= popcount(~mapped_mask);
    end else begin
      free_bits  <= kept_bits | retire_mask;
      free_count <= count_next;
    end
  end

  assign rename_stall = (free_count < prf_cnt_t'(2));

  a_alloc_1: assert property (@(posedge clock) disable iff (reset || flush)
    (used_1 || used_2) |-> free_valid_1);
  a_alloc_2: assert property (@(posedge clock) disable iff (reset || flush)
    (used_1 && used_2) |-> free_valid_2);
  a_retire_1: assert property (@(posedge clock) disable iff (reset || flush)
    retire_en_1 |-> !free_bits[retire_old_1]);
  a_retire_2: assert property (@(posedge clock) disable iff (reset || flush)
    retire_en_2 |-> !free_bits[retire_old_2]);
  a_retire_dup: assert property (@(posedge clock) disable iff (reset || flush)
    !(retire_en_1 && retire_en_2 && retire_old_1 == retire_old_2));

endmodule

// File: tb/tb_prf_free_list.sv
// tb/tb_prf_free_list.sv - table-driven bench for prf_free_list
module tb_prf_free_list;
  import prf_free_list_pkg::*;

  logic clock = 1'b0;
  logic reset, used_1, used_2, retire_en_1, retire_en_2, flush;
  prf_tag_t retire_old_1, retire_old_2;
  logic [ARF_SIZE-1:0][PRF_IDX-1:0] rrat_prf_out;
  prf_tag_t free_reg_1, free_reg_2;
  logic free_valid_1, free_valid_2, rename_stall;
  prf_cnt_t free_count;

  always #5 clock = ~clock;

  prf_free_list dut (
    .clock        (clock),
    .reset        (reset),
    .used_1       (used_1),
    .used_2       (used_2),
    .retire_en_1  (retire_en_1),
    .retire_old_1 (retire_old_1),
    .retire_en_2  (retire_en_2),
    .retire_old_2 (retire_old_2),
    .flush        (flush),
    .rrat_prf_out (rrat_prf_out),
    .free_reg_1   (free_reg_1),
    .free_reg_2   (free_reg_2),
    .free_valid_1 (free_valid_1),
    .free_valid_2 (free_valid_2),
    .free_count   (free_count),
    .rename_stall (rename_stall)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic rst, u1, u2, re1, re2;
    int   o1, o2;
    int   e_r1, e_r2, e_v1, e_v2, e_cnt, e_stall;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic rst, u1, u2, re1, input int o1, input logic re2,
                              input int o2, input int r1, r2, v1, v2, cnt, st);
    vec_t v;
    v.rst = rst; v.u1 = u1; v.u2 = u2; v.re1 = re1; v.o1 = o1; v.re2 = re2; v.o2 = o2;
    v.e_r1 = r1; v.e_r2 = r2; v.e_v1 = v1; v.e_v2 = v2; v.e_cnt = cnt; v.e_stall = st;
    return v;
  endfunction

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_out(input string tag, input int r1, r2, v1, v2, cnt, st);
    check_val({tag, ".free_reg_1"},   int'(free_reg_1),   r1);
    check_val({tag, ".free_reg_2"},   int'(free_reg_2),   r2);
    check_val({tag, ".free_valid_1"}, int'(free_valid_1), v1);
    check_val({tag, ".free_valid_2"}, int'(free_valid_2), v2);
    check_val({tag, ".free_count"},   int'(free_count),   cnt);
    check_val({tag, ".rename_stall"}, int'(rename_stall), st);
  endtask

  task automatic drive(input logic rst, u1, u2, re1, input int o1, input logic re2,
                       input int o2, input logic fl);
    reset = rst; used_1 = u1; used_2 = u2;
    retire_en_1 = re1; retire_old_1 = prf_tag_t'(o1);
    retire_en_2 = re2; retire_old_2 = prf_tag_t'(o2);
    flush = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    for (int a = 0; a < ARF_SIZE; a++) rrat_prf_out[a] = PRF_IDX'(a);
    rrat_prf_out[7] = PRF_IDX'(50);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

    vecs[0] = mk(1, 0, 0, 0, 0, 0, 0, 32, 33, 1, 1, 32, 0);
    vecs[1] = mk(0, 1, 1, 0, 0, 0, 0, 34, 35, 1, 1, 30, 0);
    vecs[2] = mk(0, 0, 1, 0, 0, 0, 0, 35, 36, 1, 1, 29, 0);
    vecs[3] = mk(0, 1, 0, 0, 0, 0, 0, 36, 37, 1, 1, 28, 0);
    vecs[4] = mk(1, 0, 0, 0, 0, 0, 0, 32, 33, 1, 1, 32, 0);
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) vecs[4+k] = mk(0, 1, 1, 0, 0, 0, 0, 32 + 2*k, 33 + 2*k, 1, 1, 32 - 2*k,
                                 (32 - 2*k) < 2 ? 1 : 0);
      else        vecs[4+k] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    vecs[21] = mk(0, 0, 0, 1, 5, 0, 0, 5, 0, 1, 0, 1, 1);
    vecs[22] = mk(0, 0, 0, 1, 10, 1, 20, 5, 10, 1, 1, 3, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].u1, vecs[i].u2, vecs[i].re1, vecs[i].o1,
            vecs[i].re2, vecs[i].o2, 1'b0);
      tick();
      check_out($sformatf("row%0d", i), vecs[i].e_r1, vecs[i].e_r2, vecs[i].e_v1,
                vecs[i].e_v2, vecs[i].e_cnt, vecs[i].e_stall);
    end

    // Alloc 5,10 while retiring 3,40: no same-cycle bypass of tag 3.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 40, 1'b0);
    #1;
    check_out("bypass_pre", 5, 10, 1, 1, 3, 0);
    tick();
    check_out("bypass_post", 3, 20, 1, 1, 3, 0);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    check_out("pre_flush", 40, 0, 1, 0, 1, 1);

    // Flush with noisy used/retire inputs; rebuilt list frees 7 and holds 50.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 40, 1'b1, 0, 1'b1);
    tick();
    check_out("flush", 7, 32, 1, 1, 32, 0);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      tick();
    end
    check_out("flush_skip50", 49, 51, 1, 1, 14, 0);

    drive(1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b0, 0, 1'b1);
    tick();
    check_out("reset_over_flush", 32, 33, 1, 1, 32, 0);
    tick();
    check_out("idle_after_reset", 32, 33, 1, 1, 32, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prf_free_list.md
# prf_free_list

Physical-register free list for the 2-wide rename stage. It tracks which PRF entries are unallocated and presents the two lowest-numbered free tags to the RAT every cycle. It consumes the RAT's `used_1`/`used_2` acknowledgements and reclaims old destination tags released by ROB retirement. On a ROB flush it rebuilds itself from the RRAT mapping.

## Interface
- `ARF_SIZE`, 32, architectural registers (global define)
- `PRF_SIZE`, 64, physical registers (global define)
- `PRF_IDX`, 6, log2(`PRF_SIZE`) (global define)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- used_1  in  1  RAT consumed one tag (slot 1)
- used_2  in  1  RAT consumed one tag (slot 2)
- retire_en_1  in  1  ROB retiring inst 1; its old tag returns to the free list
- retire_old_1  in  `PRF_IDX`  tag freed by retiring inst 1 (`PRF_dest_old_1` carried through ROB)
- retire_en_2  in  1  ROB retiring inst 2
- retire_old_2  in  `PRF_IDX`  tag freed by retiring inst 2
- flush  in  1  ROB mispredict flush
- rrat_prf_out  in  `ARF_SIZE`×`PRF_IDX`  committed ARF→PRF map
- free_reg_1  out  `PRF_IDX`  lowest free tag
- free_reg_2  out  `PRF_IDX`  second-lowest free tag
- free_valid_1  out  1  free_reg_1 is meaningful
- free_valid_2  out  1  free_reg_2 is meaningful
- free_count  out  `PRF_IDX`+1  number of free entries
- rename_stall  out  1  free_count < 2; the ID stage must not dispatch

## Operation
- State: `free_bits[`PRF_SIZE`-1:0]` register, bit=1 means free; `free_count` register.
- free_reg_1/2 and valids are combinational from `free_bits`, giving zero latency. With no free bits, the tag outputs are 0 and the valids are 0.
- Allocation count n = used_1 + used_2. The block clears the n lowest free bits.
- used_2 alone (used_1=0) consumes free_reg_1. This matches the RAT, which then maps inst 2 to free_reg_1.
- Retire: each retire_en_k sets free_bits[retire_old_k].
- Next state when not flushing: free_bits' = (free_bits & ~alloc_mask) | retire_mask. free_count' = free_count − n + (number of retire_en set).
- Flush: free_bits' is set to the complement of the set of tags present in rrat_prf_out, and free_count' is recomputed by popcount. used_* and retire_* are ignored on that cycle.
- Priority: reset > flush > normal.
- Reset: free_bits = 1 for tags `ARF_SIZE`..`PRF_SIZE`-1 and 0 for tags 0..`ARF_SIZE`-1, matching the RAT identity map. free_count = `PRF_SIZE`−`ARF_SIZE`.
- Protocol violations:
  - used_k asserted without the matching free_valid.
  - retire of a tag that is already free.
  - retire_old_1 == retire_old_2 with both enables set.
  - These are simulation assertions only. In hardware, the over-allocation is dropped (the bit stays cleared) and the duplicate retire is idempotent.

## Timing
- Tag presentation: same cycle as state, with no registered output stage.
- Allocation is visible on the next cycle: the new free_reg_1/2 skip the consumed tags.
- Retired tags become allocatable the cycle after retire_en. There is no same-cycle bypass into free_reg_*.
- Simultaneous allocate and retire in one cycle are both applied.
- Flush: the rebuilt list is valid the cycle after flush. The RAT reloads from the RRAT on the same edge, so the two stay consistent.
- Reset mid-operation: all pending alloc, retire and flush activity is discarded and the reset state is loaded on that edge.
- rename_stall is combinational from free_count.

## Structure
- `ARF_SIZE`, `PRF_SIZE`, `PRF_IDX` and the `SD` delay macro come from the shared sys_defs header. No new global constants are introduced.
- Sub-module `prf_two_lowest`: a combinational finder that takes a `PRF_SIZE` bit vector and returns the lowest and second-lowest set indices plus their valids. It is implemented as two cascaded priority encoders, with the second operating on the vector with the first hit masked.
- The top level contains the bitmap register, the count register, the alloc/retire mask builders, and the flush rebuild (decode of all `ARF_SIZE` RRAT entries ORed into a mapped mask).

## Test plan
- Reset, then no activity → free_reg_1=32, free_reg_2=33, both valid, free_count=32, rename_stall=0.
- Cycle 1: used_1=used_2=1 → next cycle free_reg_1=34, free_reg_2=35, free_count=30. Cycle 2: used_2 alone → next cycle free_reg_1=35, count=29.
- Allocate every tag 32..63 (16 double-allocates) → free_count=0, valids=0, rename_stall=1. Then retire_old_1=5 → next cycle free_reg_1=5, free_valid_2=0, stall still 1.
- Same-cycle used_1=used_2=1 with retire_old_1=3, retire_old_2=40 (40 previously allocated) → net count unchanged, and tag 3 is not offered until the following cycle.
- After several allocations, flush with rrat_prf_out mapping ARF i→i except ARF 7→50 → next cycle tag 7 is free, tag 50 is not, and free_count=32. used/retire inputs on the flush cycle have no effect.
- Assert reset during a flush cycle → the reset state is loaded, identical to the first scenario.
